// File: rtl/sram_pkg.sv
// Shared SRAM column constants: rail voltages and write-driver state encoding.
// Used by the write driver and the read-path sense amplifier.
package sram_pkg;

   localparam real VDD  = 1.5;
   localparam real VSS  = 0.0;
   localparam real VNEG = -0.2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRECH = 2'd1,
      DRIVE = 2'd2,
      RECOV = 2'd3
   } wd_state_t;

endpackage

// File: rtl/wd_column.sv
// Per-column bitline voltage mapping; purely combinational from registered controls.
// Latency: none. Backpressure: none (no handshake).
// Optional negative-bitline assist under SRAM_WRITE_ASSIST_EN.
module wd_column
   import sram_pkg::*;
(
   input  logic data,
   input  logic drive,
   input  logic assist_first,
   output real  bl,
   output real  blb
);

   real low_lvl;

`ifdef SRAM_WRITE_ASSIST_EN
   always_comb begin
      low_lvl = VSS;
      if (assist_first) low_lvl = VNEG;
   end
`else
   logic unused_assist;
   assign unused_assist = assist_first;

   always_comb begin
      low_lvl = VSS;
   end
`endif

   // Undriven lines sit at VDD; drive pulls exactly one line of the pair low.
   always_comb begin
      bl  = VDD;
      blb = VDD;
      if (drive) begin
         if (data) blb = low_lvl;
         else      bl  = low_lvl;
      end
   end

endmodule

// File: rtl/sram_write_driver.sv
// SRAM write driver: equalize -> drive -> recover sequence per accepted word (macro SRAM_WRITE_ASSIST_EN).
// Latency: done PRE_CYCLES+DRIVE_CYCLES+1 cycles after accept; one idle cycle between writes.
// Backpressure: wr_ready high only in IDLE; requests while busy are ignored, not queued.
module sram_write_driver
   import sram_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int PRE_CYCLES   = 2,
   parameter int DRIVE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             eq_en,
   output logic             wl_en,
   output logic             done,
   output real              bl  [WIDTH],
   output real              blb [WIDTH]
);

   generate
      if (PRE_CYCLES < 1 || PRE_CYCLES > 15) begin : g_bad_pre
         $error("PRE_CYCLES must be in 1..15");
      end
      if (DRIVE_CYCLES < 1 || DRIVE_CYCLES > 15) begin : g_bad_drive
         $error("DRIVE_CYCLES must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
   localparam logic [3:0] DRV_LOAD = 4'(DRIVE_CYCLES - 1);

   wd_state_t        state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             drive;
   logic             assist_first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Outputs decode from state_q only, so no input reaches an output combinationally.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      wr_ready = 1'b0;
      eq_en    = 1'b0;
      wl_en    = 1'b0;
      done     = 1'b0;
      drive    = 1'b0;
      case (state_q)
         IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               data_d  = wr_data;
               cnt_d   = PRE_LOAD;
               state_d = PRECH;
            end
         end
         PRECH: begin
            eq_en = 1'b1;
            if (cnt_q == 4'd0) begin
               cnt_d   = DRV_LOAD;
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DRIVE: begin
            wl_en = 1'b1;
            drive = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = RECOV;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RECOV: begin
            eq_en   = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Counter still holds its load value only in the first drive cycle.
   assign assist_first = (state_q == DRIVE) && (cnt_q == DRV_LOAD);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_col
         wd_column u_col (
            .data         (data_q[i]),
            .drive        (drive),
            .assist_first (assist_first),
            .bl           (bl[i]),
            .blb          (blb[i])
         );
      end
   endgenerate

endmodule
